// File: rtl/wave_gen_pkg.sv
// Shared codes for the DAC waveform source: waveform selects, FSM encoding,
// DAC mid-scale and the amplitude scaler.
package wave_gen_pkg;

  localparam logic [1:0] WAVE_SINE = 2'd0;
  localparam logic [1:0] WAVE_TRI  = 2'd1;
  localparam logic [1:0] WAVE_SAW  = 2'd2;
  localparam logic [1:0] WAVE_SQR  = 2'd3;

  localparam logic [7:0] DAC_MID = 8'h80;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC1 = 2'd1,
    ST_CALC2 = 2'd2,
    ST_READY = 2'd3
  } state_t;

  // Scales around mid-scale; floor shift keeps the result in 0..254.
  function automatic logic [7:0] scale_sample(input logic [7:0] raw, input logic [7:0] amp);
    logic signed [8:0]  s;
    logic signed [17:0] prod;
    logic signed [17:0] shifted;
    s       = $signed({1'b0, raw}) - 9'sd128;
    prod    = $signed({{9{s[8]}}, s}) * $signed({10'd0, amp});
    shifted = prod >>> 8;
    return shifted[7:0] + DAC_MID;
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Quarter-wave sine table, T[k] = round(127*sin(pi/2*(k+0.5)/64)), with a
// registered output so the value lines up with the end of CALC1.
module sine_quarter_rom (
  input  logic       clk_12m,
  input  logic       rst_n,
  input  logic [5:0] addr,
  output logic [6:0] data
);

  logic [6:0] lookup;

  always_comb begin
    lookup = 7'd0;
    case (addr)
      6'd0:  lookup = 7'd2;   6'd1:  lookup = 7'd5;   6'd2:  lookup = 7'd8;   6'd3:  lookup = 7'd11;
      6'd4:  lookup = 7'd14;  6'd5:  lookup = 7'd17;  6'd6:  lookup = 7'd20;  6'd7:  lookup = 7'd23;
      6'd8:  lookup = 7'd26;  6'd9:  lookup = 7'd29;  6'd10: lookup = 7'd32;  6'd11: lookup = 7'd35;
      6'd12: lookup = 7'd38;  6'd13: lookup = 7'd41;  6'd14: lookup = 7'd44;  6'd15: lookup = 7'd47;
      6'd16: lookup = 7'd50;  6'd17: lookup = 7'd53;  6'd18: lookup = 7'd56;  6'd19: lookup = 7'd58;
      6'd20: lookup = 7'd61;  6'd21: lookup = 7'd64;  6'd22: lookup = 7'd67;  6'd23: lookup = 7'd69;
      6'd24: lookup = 7'd72;  6'd25: lookup = 7'd74;  6'd26: lookup = 7'd77;  6'd27: lookup = 7'd79;
      6'd28: lookup = 7'd82;  6'd29: lookup = 7'd84;  6'd30: lookup = 7'd86;  6'd31: lookup = 7'd89;
      6'd32: lookup = 7'd91;  6'd33: lookup = 7'd93;  6'd34: lookup = 7'd95;  6'd35: lookup = 7'd97;
      6'd36: lookup = 7'd99;  6'd37: lookup = 7'd101; 6'd38: lookup = 7'd103; 6'd39: lookup = 7'd105;
      6'd40: lookup = 7'd106; 6'd41: lookup = 7'd108; 6'd42: lookup = 7'd110; 6'd43: lookup = 7'd111;
      6'd44: lookup = 7'd113; 6'd45: lookup = 7'd114; 6'd46: lookup = 7'd115; 6'd47: lookup = 7'd117;
      6'd48: lookup = 7'd118; 6'd49: lookup = 7'd119; 6'd50: lookup = 7'd120; 6'd51: lookup = 7'd121;
      6'd52: lookup = 7'd122; 6'd53: lookup = 7'd123; 6'd54: lookup = 7'd124; 6'd55: lookup = 7'd124;
      6'd56: lookup = 7'd125; 6'd57: lookup = 7'd125; 6'd58: lookup = 7'd126; 6'd59: lookup = 7'd126;
      6'd60: lookup = 7'd127; 6'd61: lookup = 7'd127; 6'd62: lookup = 7'd127; 6'd63: lookup = 7'd127;
      default: lookup = 7'd0;
    endcase
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) data <= 7'd0;
    else        data <= lookup;
  end

endmodule

// File: rtl/dac_wave_source.sv
// DAC sample generator: phase accumulator + waveform shaper + amplitude scaler,
// stepping to the next sample on each synchronized I2C data-byte ACK.
module dac_wave_source
  import wave_gen_pkg::*;
#(
  parameter int PHASE_W = 16
) (
  input  logic               clk_12m,
  input  logic               rst_n,
  input  logic               sample_ack,
  input  logic               enable,
  input  logic [1:0]         wave_sel,
  input  logic [PHASE_W-1:0] freq_word,
  input  logic [7:0]         amplitude,
  output logic [7:0]         sample_data,
  output logic               sample_valid,
  output logic               underrun,
  output logic [15:0]        sample_count,
  output logic [1:0]         state_dbg
);

  // Handshake: sample_valid is high only in READY and sample_data is stable
  // while it is high; a rising sample_ack edge consumes the sample, and valid
  // drops the clock after the synchronized pulse reaches the FSM.

  logic [1:0]         sync_q;
  logic               ack_d;
  logic               ack_pulse;
  state_t             state, state_next;
  logic [PHASE_W-1:0] phase;
  logic [1:0]         wave_q;
  logic [7:0]         amp_q;
  logic [7:0]         p_q;
  logic [5:0]         rom_addr;
  logic [6:0]         rom_data;
  logic [7:0]         raw;

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= 2'b00;
      ack_d     <= 1'b0;
      ack_pulse <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], sample_ack};
      ack_d     <= sync_q[1];
      ack_pulse <= sync_q[1] & ~ack_d;
    end
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_next = ST_CALC1;
        ST_CALC1: state_next = ST_CALC2;
        ST_CALC2: state_next = ST_READY;
        ST_READY: if (ack_pulse) state_next = ST_CALC1;
        default:  state_next = ST_IDLE;
      endcase
    end
  end

  // Odd quadrants read the quarter table backwards.
  assign rom_addr = phase[PHASE_W-3 -: 6] ^ {6{phase[PHASE_W-2]}};

  sine_quarter_rom u_rom (
    .clk_12m (clk_12m),
    .rst_n   (rst_n),
    .addr    (rom_addr),
    .data    (rom_data)
  );

  always_comb begin
    raw = p_q;
    case (wave_q)
      WAVE_SINE: raw = p_q[7] ? (8'd127 - {1'b0, rom_data}) : (8'd128 + {1'b0, rom_data});
      WAVE_TRI:  raw = p_q[7] ? (8'd255 - {p_q[6:0], 1'b0}) : {p_q[6:0], 1'b0};
      WAVE_SAW:  raw = p_q;
      default:   raw = p_q[7] ? 8'h00 : 8'hFF;
    endcase
  end

  always_ff @(posedge clk_12m or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= '0;
      wave_q       <= WAVE_SINE;
      amp_q        <= 8'd0;
      p_q          <= 8'd0;
      sample_data  <= DAC_MID;
      sample_count <= 16'd0;
      underrun     <= 1'b0;
    end else if (!enable) begin
      sample_data <= DAC_MID;
      underrun    <= 1'b0;
    end else begin
      if (ack_pulse && state != ST_READY) underrun <= 1'b1;
      case (state)
        ST_IDLE: begin
          phase        <= '0;
          sample_count <= 16'd0;
        end
        ST_CALC1: begin
          wave_q <= wave_sel;
          amp_q  <= amplitude;
          p_q    <= phase[PHASE_W-1 -: 8];
        end
        ST_CALC2: begin
          sample_data  <= scale_sample(raw, amp_q);
          sample_count <= sample_count + 16'd1;
        end
        ST_READY: begin
          if (ack_pulse) phase <= phase + freq_word;
        end
        default: ;
      endcase
    end
  end

  assign sample_valid = (state == ST_READY);
  assign state_dbg    = state;

endmodule

// File: tb/tb_dac_wave_source.sv
// Directed bench for dac_wave_source: vector table of single samples plus
// hand-written sequences for sweep, underrun, enable drop and async reset.
module tb_dac_wave_source;

  logic        clk_12m = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_ack = 1'b0;
  logic        enable = 1'b0;
  logic [1:0]  wave_sel = 2'd0;
  logic [15:0] freq_word = 16'd0;
  logic [7:0]  amplitude = 8'd0;
  logic [7:0]  sample_data;
  logic        sample_valid;
  logic        underrun;
  logic [15:0] sample_count;
  logic [1:0]  state_dbg;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [1:0]  wave;
    logic [7:0]  amp;
    logic [15:0] freq;
    int          steps;
    logic [7:0]  exp_data;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[14];

  dac_wave_source #(.PHASE_W(16)) dut (
    .clk_12m      (clk_12m),
    .rst_n        (rst_n),
    .sample_ack   (sample_ack),
    .enable       (enable),
    .wave_sel     (wave_sel),
    .freq_word    (freq_word),
    .amplitude    (amplitude),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .underrun     (underrun),
    .sample_count (sample_count),
    .state_dbg    (state_dbg)
  );

  // clock / watchdog
  always #5 clk_12m = ~clk_12m;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, actual, expected);
    end
  endtask

  // Independent reference: real-valued sine table and integer floor division.
  function automatic logic [7:0] model_sample(input int wave, input int p, input int amp);
    int raw, q, i, k, t, prod, sc;
    real ang;
    raw = 0;
    case (wave)
      0: begin
        q = p / 64;
        i = p % 64;
        k = (q % 2 == 1) ? 63 - i : i;
        ang = 3.14159265358979 * (real'(k) + 0.5) / 128.0;
        t = $rtoi($floor(127.0 * $sin(ang) + 0.5));
        raw = (q < 2) ? 128 + t : 127 - t;
      end
      1: raw = (p >= 128) ? 255 - 2 * (p - 128) : 2 * p;
      2: raw = p;
      default: raw = (p >= 128) ? 0 : 255;
    endcase
    prod = (raw - 128) * amp;
    sc = (prod >= 0) ? prod / 256 : -((-prod + 255) / 256);
    return 8'(128 + sc);
  endfunction

  // driver tasks
  task automatic start_wave(input logic [1:0] w, input logic [7:0] a, input logic [15:0] f,
                            output int lat);
    enable = 1'b0;
    @(negedge clk_12m);
    @(negedge clk_12m);
    wave_sel = w;
    amplitude = a;
    freq_word = f;
    enable = 1'b1;
    lat = 0;
    while (lat < 10 && !sample_valid) begin
      @(negedge clk_12m);
      lat++;
    end
  endtask

  task automatic do_ack(output int lat);
    bit saw_low;
    saw_low = 1'b0;
    lat = 0;
    sample_ack = 1'b1;
    while (lat < 20) begin
      @(negedge clk_12m);
      lat++;
      if (lat == 2) sample_ack = 1'b0;
      if (!sample_valid) saw_low = 1'b1;
      else if (saw_low) break;
    end
    sample_ack = 1'b0;
    check("ack_new_sample", {31'd0, saw_low & sample_valid}, 32'd1);
  endtask

  initial begin
    int lat;
    int found;

    vecs[0]  = '{2'd3, 8'd128, 16'h4000, 0, 8'd191, 16'd1};
    vecs[1]  = '{2'd3, 8'd128, 16'h4000, 1, 8'd191, 16'd2};
    vecs[2]  = '{2'd3, 8'd128, 16'h4000, 2, 8'd64,  16'd3};
    vecs[3]  = '{2'd3, 8'd128, 16'h4000, 3, 8'd64,  16'd4};
    vecs[4]  = '{2'd3, 8'd0,   16'h4000, 2, 8'd128, 16'd3};
    vecs[5]  = '{2'd0, 8'd255, 16'h4000, 0, 8'd129, 16'd1};
    vecs[6]  = '{2'd0, 8'd255, 16'h4000, 1, 8'd254, 16'd2};
    vecs[7]  = '{2'd0, 8'd255, 16'h4000, 2, 8'd125, 16'd3};
    vecs[8]  = '{2'd0, 8'd255, 16'h4000, 3, 8'd0,   16'd4};
    vecs[9]  = '{2'd1, 8'd255, 16'h2000, 1, 8'd64,  16'd2};
    vecs[10] = '{2'd1, 8'd255, 16'h2000, 5, 8'd190, 16'd6};
    vecs[11] = '{2'd2, 8'd128, 16'h1000, 3, 8'd88,  16'd4};
    vecs[12] = '{2'd0, 8'd128, 16'h1000, 5, 8'd186, 16'd6};
    vecs[13] = '{2'd0, 8'd200, 16'hE000, 1, 8'd57,  16'd2};

    // reset block
    rst_n = 1'b0;
    repeat (3) @(negedge clk_12m);
    check("rst_data",  {24'd0, sample_data}, 32'h80);
    check("rst_valid", {31'd0, sample_valid}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_count", {16'd0, sample_count}, 32'd0);
    check("rst_state", {30'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk_12m);
    check("idle_disabled_valid", {31'd0, sample_valid}, 32'd0);

    // vector table
    for (int v = 0; v < 14; v++) begin
      start_wave(vecs[v].wave, vecs[v].amp, vecs[v].freq, lat);
      check($sformatf("vec%0d_enable_latency", v), lat, 32'd3);
      for (int s = 0; s < vecs[v].steps; s++) do_ack(lat);
      check($sformatf("vec%0d_data", v), {24'd0, sample_data}, {24'd0, vecs[v].exp_data});
      check($sformatf("vec%0d_count", v), {16'd0, sample_count}, {16'd0, vecs[v].exp_count});
      check($sformatf("vec%0d_underrun", v), {31'd0, underrun}, 32'd0);
    end

    // sawtooth sweep through a full phase wrap, scoreboarded
    for (int k = 0; k <= 256; k++) exp_q.push_back(model_sample(2, k % 256, 255));
    start_wave(2'd2, 8'd255, 16'h0100, lat);
    check("saw_first", {24'd0, sample_data}, {24'd0, exp_q.pop_front()});
    for (int k = 1; k <= 256; k++) begin
      do_ack(lat);
      if (k == 1) check("ack_latency", lat, 32'd6);
      if (k == 129) check("saw_129th_mid", {24'd0, sample_data}, 32'h80);
      check($sformatf("saw_%0d", k), {24'd0, sample_data}, {24'd0, exp_q.pop_front()});
    end
    check("saw_count", {16'd0, sample_count}, 32'd257);
    check("saw_underrun", {31'd0, underrun}, 32'd0);

    // two ack edges two clocks apart: one advance, underrun set
    start_wave(2'd2, 8'd255, 16'h4000, lat);
    check("ur_first", {24'd0, sample_data}, 32'd0);
    sample_ack = 1'b1;
    @(negedge clk_12m);
    sample_ack = 1'b0;
    @(negedge clk_12m);
    sample_ack = 1'b1;
    @(negedge clk_12m);
    sample_ack = 1'b0;
    repeat (2) @(negedge clk_12m);
    lat = 0;
    while (lat < 10 && !sample_valid) begin
      @(negedge clk_12m);
      lat++;
    end
    check("ur_valid", {31'd0, sample_valid}, 32'd1);
    check("ur_single_advance", {24'd0, sample_data}, 32'd64);
    check("ur_count", {16'd0, sample_count}, 32'd2);
    check("ur_flag", {31'd0, underrun}, 32'd1);
    enable = 1'b0;
    @(negedge clk_12m);
    check("ur_cleared", {31'd0, underrun}, 32'd0);
    check("ur_off_data", {24'd0, sample_data}, 32'h80);
    check("ur_off_valid", {31'd0, sample_valid}, 32'd0);

    // enable dropped while the next sample is in CALC2
    start_wave(2'd3, 8'd128, 16'h4000, lat);
    sample_ack = 1'b1;
    found = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk_12m);
      if (i == 1) sample_ack = 1'b0;
      if (state_dbg == 2'd2) begin
        found = 1;
        break;
      end
    end
    sample_ack = 1'b0;
    check("drop_reached_calc2", found, 32'd1);
    enable = 1'b0;
    @(negedge clk_12m);
    check("drop_state", {30'd0, state_dbg}, 32'd0);
    check("drop_data", {24'd0, sample_data}, 32'h80);
    check("drop_valid", {31'd0, sample_valid}, 32'd0);
    check("drop_count", {16'd0, sample_count}, 32'd1);

    // asynchronous reset while READY, then restart with enable held high
    start_wave(2'd3, 8'd128, 16'h4000, lat);
    do_ack(lat);
    check("pre_rst_count", {16'd0, sample_count}, 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_data", {24'd0, sample_data}, 32'h80);
    check("async_rst_valid", {31'd0, sample_valid}, 32'd0);
    check("async_rst_count", {16'd0, sample_count}, 32'd0);
    check("async_rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clk_12m);
    rst_n = 1'b1;
    lat = 0;
    while (lat < 10 && !sample_valid) begin
      @(negedge clk_12m);
      lat++;
    end
    check("post_rst_latency", lat, 32'd3);
    check("post_rst_data", {24'd0, sample_data}, 32'd191);
    check("post_rst_count", {16'd0, sample_count}, 32'd1);

    // final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_wave_source.md
# dac_wave_source

Waveform sample generator feeding the PCF8591 DAC write path. Produces one 8-bit sample at a time from a phase accumulator (sine, triangle, sawtooth or square) with amplitude scaling around mid-scale 0x80. Advances to the next sample each time the I2C master acknowledges a DAC data byte. Sits directly upstream of the I2C master config stage; `sample_data` drives its register-data input.

## Interface
Parameters:
- `PHASE_W`, 16, phase accumulator width; phase index = top 8 bits.

Ports:
- `clk_12m`  in  1  system clock, 12 MHz.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sample_ack`  in  1  data-byte ACK strobe from the I2C clock domain; rising edge = current sample consumed.
- `enable`  in  1  run/stop.
- `wave_sel`  in  2  0 sine, 1 triangle, 2 sawtooth, 3 square.
- `freq_word`  in  PHASE_W  phase increment per sample.
- `amplitude`  in  8  gain, unsigned, /256.
- `sample_data`  out  8  current DAC sample.
- `sample_valid`  out  1  `sample_data` is stable and current.
- `underrun`  out  1  sticky: ACK arrived while sample not valid.
- `sample_count`  out  16  samples produced since enable rose; wraps.

## Operation
- `sample_ack` passes through a 2-FF synchronizer plus an edge register; `ack_pulse` = rising edge, one clock wide.
- FSM: IDLE, CALC1, CALC2, READY.
  - IDLE: `sample_data`=0x80, valid=0. `enable`=1 -> phase=0, count=0, go CALC1.
  - CALC1: latch `wave_sel`/`amplitude`; compute raw sample from phase top byte p (registered). Go CALC2.
  - CALC2: scale, register `sample_data`, count+1. Go READY with valid=1.
  - READY: `ack_pulse` -> phase += `freq_word` (mod 2^PHASE_W), valid=0, go CALC1.
  - Any state: `enable`=0 -> IDLE next clock; `sample_data`=0x80, valid=0; `underrun` cleared.
- Raw sample from p[7:0]:
  - Sine: q=p[7:6], i=p[5:0]; T = quarter ROM, 64 entries, T[k]=round(127*sin(pi/2*(k+0.5)/64)). Index is i for q even, 63-i for q odd. Raw = 128+T for q<2, 127-T for q>=2.
  - Triangle: p[7] ? 255-{p[6:0],0} : {p[6:0],0}.
  - Sawtooth: p.
  - Square: p[7] ? 0x00 : 0xFF.
- Scaling: s = raw-128 (signed 9b); prod = s * {0,amplitude} (signed 18b); out = 128 + (prod >>> 8), arithmetic floor shift. Result is always 0..254 with no clipping.
- `ack_pulse` outside READY while enabled sets `underrun`. The pulse is otherwise ignored; no phase advance.
- Config changes take effect at the next CALC1 only; the sample in flight is unaffected.

## Timing
- Reset values: `sample_data`=0x80, `sample_valid`=0, `underrun`=0, `sample_count`=0, phase=0, FSM IDLE, sync FFs 0.
- `sample_ack` edge -> `ack_pulse`: 3 clk_12m. `ack_pulse` -> valid low next clock. New sample valid 3 clocks after `ack_pulse` (CALC1, CALC2, READY).
- `enable` rise -> first sample valid after 3 clocks.
- Total ack-to-new-sample is 6 clocks (0.5 us). This is far below one I2C byte time at 100/400 kHz, so underrun only flags faults.
- `sample_count` increments in the CALC2 -> READY transition and wraps 0xFFFF -> 0x0000.

## Structure
- Package `wave_gen_pkg`: wave_sel codes (WAVE_SINE/TRI/SAW/SQR), FSM state encoding, DAC_MID=8'h80.
- Sub-module `sine_quarter_rom`: 64x7 registered lookup (6b addr in, 7b data out, 1-clock latency, aligned with CALC1).
- Synchronizer, FSM, phase accumulator and scaler stay in `dac_wave_source`.

## Test plan
- Reset mid-READY -> all outputs return to reset values immediately (async); after release with `enable`=1, first sample arrives 3 clocks later.
- Sawtooth, amplitude=255, freq_word=0x0100, 256 acks -> samples 0x00, 0x01, … 0x80 (129th) … 0xFE; 257th sample is 0x00 again; `sample_count` 257.
- Square, amplitude=128, freq_word=0x4000 -> samples 191, 191, 64, 64 repeating; amplitude=0 -> constant 0x80.
- Sine, amplitude=255, freq_word=0x4000 -> phases 0x00/0x40/0x80/0xC0. Check against T model: 128+T[0], 128+T[63] scaled, etc.
- Two `sample_ack` edges 2 clocks apart -> second sets `underrun`=1, exactly one phase advance. `enable` low clears it.
- `enable` dropped during CALC2 -> next clock IDLE, `sample_data`=0x80, valid=0, no count increment.
